// File: rtl/enc_arbiter_if.sv
// Requester, response and encoder-core signal bundle for enc_arbiter.
interface enc_arbiter_if;
  localparam int unsigned PT_W  = 64;
  localparam int unsigned KEY_W = 80;

  logic             req0_valid;
  logic             req0_ready;
  logic [PT_W-1:0]  req0_pt;
  logic [KEY_W-1:0] req0_key;
  logic             req1_valid;
  logic             req1_ready;
  logic [PT_W-1:0]  req1_pt;
  logic [KEY_W-1:0] req1_key;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [PT_W-1:0]  rsp0_ct;
  logic             rsp0_err;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [PT_W-1:0]  rsp1_ct;
  logic             rsp1_err;

  logic             core_start;
  logic [PT_W-1:0]  core_pt;
  logic [KEY_W-1:0] core_key;
  logic             core_done;
  logic [PT_W-1:0]  core_ct;
  logic             core_rst_n;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_pt, req0_key, req1_valid, req1_pt, req1_key,
    input  rsp0_ready, rsp1_ready, core_done, core_ct,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_ct, rsp0_err, rsp1_valid, rsp1_ct, rsp1_err,
    output core_start, core_pt, core_key, core_rst_n
  );

  // Requesters and core side
  modport master (
    output req0_valid, req0_pt, req0_key, req1_valid, req1_pt, req1_key,
    output rsp0_ready, rsp1_ready, core_done, core_ct,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_ct, rsp0_err, rsp1_valid, rsp1_ct, rsp1_err,
    input  core_start, core_pt, core_key, core_rst_n
  );
endinterface

// File: rtl/enc_arbiter.sv
// Two-port round-robin arbiter in front of a shared encoder core, with a
// watchdog that aborts a job the core never finishes.
module enc_arbiter #(
  parameter logic [5:0] TIMEOUT = 6'd40
) (
  input  logic         clk,
  input  logic         reset,
  enc_arbiter_if.slave bus
);
  localparam int unsigned PT_W  = 64;
  localparam int unsigned KEY_W = 80;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

  state_t             state_q, state_d;
  logic               rr_q, owner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PT_W-1:0]    op_pt_q;
  logic [KEY_W-1:0]   op_key_q;
  logic               grant0_c, grant1_c, finish_c, abort_c, hs_c;
  logic [PT_W-1:0]    res_ct_c;
  logic               res_err_c;

  logic               core_start_q, core_rst_n_q;
  logic               rsp0_valid_q, rsp1_valid_q, rsp0_err_q, rsp1_err_q;
  logic [PT_W-1:0]    rsp0_ct_q, rsp1_ct_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, grant and job-completion decode
  always_comb begin
    state_d   = state_q;
    grant0_c  = 1'b0;
    grant1_c  = 1'b0;
    finish_c  = 1'b0;
    abort_c   = 1'b0;
    hs_c      = 1'b0;
    res_ct_c  = '0;
    res_err_c = 1'b0;
    case (state_q)
      IDLE: begin
        // ready is combinational on valid, so it must stay low while reset is held
        if (reset && (bus.req0_valid || bus.req1_valid)) begin
          if (bus.req0_valid && (!bus.req1_valid || !rr_q)) grant0_c = 1'b1;
          else                                             grant1_c = 1'b1;
          state_d = START;
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        // done has priority over the watchdog firing in the same cycle
        if (bus.core_done) begin
          finish_c = 1'b1;
          res_ct_c = bus.core_ct;
          state_d  = RESP;
        end else if (cnt_q == TIMEOUT) begin
          finish_c  = 1'b1;
          abort_c   = 1'b1;
          res_err_c = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          hs_c    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;

  // Owner / round-robin pointer, operand capture and saturating watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q     <= 1'b0;
      owner_q  <= 1'b0;
      op_pt_q  <= '0;
      op_key_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (grant0_c || grant1_c) begin
        owner_q  <= grant1_c;
        rr_q     <= ~grant1_c;
        op_pt_q  <= grant1_c ? bus.req1_pt  : bus.req0_pt;
        op_key_q <= grant1_c ? bus.req1_key : bus.req0_key;
      end
      if (state_q == START)                       cnt_q <= '0;
      else if (state_q == BUSY && cnt_q != '1)    cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Registered core controls and per-port responses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_start_q <= 1'b0;
      core_rst_n_q <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp0_ct_q    <= '0;
      rsp1_ct_q    <= '0;
    end else begin
      core_start_q <= (state_d == START);
      core_rst_n_q <= ~abort_c;
      if (finish_c) begin
        rsp0_valid_q <= ~owner_q;
        rsp1_valid_q <= owner_q;
        rsp0_ct_q    <= owner_q ? '0 : res_ct_c;
        rsp1_ct_q    <= owner_q ? res_ct_c : '0;
        rsp0_err_q   <= ~owner_q & res_err_c;
        rsp1_err_q   <= owner_q & res_err_c;
      end else if (hs_c) begin
        rsp0_valid_q <= 1'b0;
        rsp1_valid_q <= 1'b0;
        rsp0_ct_q    <= '0;
        rsp1_ct_q    <= '0;
        rsp0_err_q   <= 1'b0;
        rsp1_err_q   <= 1'b0;
      end
    end
  end

  assign bus.core_start = core_start_q;
  assign bus.core_rst_n = core_rst_n_q;
  assign bus.core_pt    = op_pt_q;
  assign bus.core_key   = op_key_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_ct    = rsp0_ct_q;
  assign bus.rsp1_ct    = rsp1_ct_q;
  assign bus.rsp0_err   = rsp0_err_q;
  assign bus.rsp1_err   = rsp1_err_q;
endmodule

// File: doc/enc_arbiter.md
ENC_ARBITER -- requirements
Module: enc_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 6'd40, max cycles from core_start to core_done before abort.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  in  1  requester 0/1 has a job.
REQ-005 req0_ready / req1_ready  out  1  job accepted this cycle.
REQ-006 req0_pt / req1_pt  in  64  plaintext; req0_key / req1_key  in  80  key.
REQ-007 rsp0_valid / rsp1_valid  out  1  result available; rsp0_ready / rsp1_ready  in  1  requester takes result.
REQ-008 rsp0_ct / rsp1_ct  out  64  ciphertext; rsp0_err / rsp1_err  out  1  job aborted by timeout.
REQ-009 core_start  out  1  one-cycle start pulse to shared encoder core.
REQ-010 core_pt  out  64, core_key  out  80  operands to core.
REQ-011 core_done  in  1, core_ct  in  64  core completion pulse and result.
REQ-012 core_rst_n  out  1  active-low synchronous reset to the core.

Function
REQ-013 States: IDLE, START, BUSY, RESP; single job in flight at any time.
REQ-014 IDLE: if any reqN_valid, grant one, pulse reqN_ready for exactly that cycle, latch reqN_pt/reqN_key into operand registers, record owner, go START.
REQ-015 Arbitration round-robin: pointer rr (1 bit); when both valid, grant port rr; after each grant rr := ~owner; single valid granted regardless of rr.
REQ-016 START: core_start = 1 for one cycle, watchdog counter cleared to 0, go BUSY.
REQ-017 core_pt/core_key driven from operand registers, held stable from START until exit of BUSY.
REQ-018 BUSY: counter increments each cycle; core_done = 1 -> capture core_ct, err := 0, go RESP.
REQ-019 BUSY: counter == TIMEOUT with core_done = 0 -> ct := 64'h0, err := 1, core_rst_n = 0 for one cycle, go RESP.
REQ-020 core_done and counter == TIMEOUT in same cycle -> done wins (err = 0).
REQ-021 core_done outside BUSY ignored.
REQ-022 RESP: rspN_valid = 1 for owner only, rspN_ct/rspN_err held stable until rspN_ready = 1; on that cycle go IDLE.
REQ-023 Non-owner rsp port: valid = 0, ct = 0, err = 0.
REQ-024 reqN_ready never asserted outside IDLE; requests during START/BUSY/RESP wait (requester holds valid).
REQ-025 Latency, no contention, rsp_ready held 1: req accepted cycle T, core_start T+1, rsp_valid first cycle after core_done.
REQ-026 New grant no earlier than cycle after RESP handshake (one IDLE cycle minimum between jobs).
REQ-027 Counter 6 bits, saturates, never wraps.

Reset
REQ-028 reset = 0 asynchronously forces: state IDLE, rr = 0, counter = 0, all ready/valid/err = 0, rsp ct = 0, core_start = 0, core_rst_n = 0.
REQ-029 core_rst_n returns to 1 on first clk edge after reset release; reset mid-job discards job, no response issued.

Verification
REQ-030 Stub core: core_done 26 cycles after core_start, core_ct = pt ^ key[63:0]; req0 pt=64'h0123456789ABCDEF, key=80'h0 -> rsp0_valid, rsp0_ct=64'h0123456789ABCDEF, err=0, at cycle T+28.
REQ-031 Both valid at reset exit -> port 0 granted first, port 1 granted after port 0 response handshake; third simultaneous round grants 0 again.
REQ-032 Stub never asserts core_done -> after 40 BUSY cycles rsp_err=1, rsp_ct=0, core_rst_n low exactly one cycle.
REQ-033 rsp0_ready held 0 for 10 cycles -> rsp0_valid/ct stable, req1_ready stays 0 until handshake.
REQ-034 reset asserted mid-BUSY -> all outputs zero immediately (before next edge); after release, no stale response; next job completes normally.
REQ-035 core_done on same cycle counter reaches 40 -> rsp_err=0, core_ct delivered, core_rst_n stays 1.
